// File: rtl/banner_pkg.sv
// Shared types and geometry for the banner overlay writer and draw-side address generation.
package banner_pkg;

  localparam int unsigned DEFAULT_BANNER_W = 80;
  localparam int unsigned DEFAULT_BANNER_H = 45;
  localparam int unsigned BANNER_PIXELS    = DEFAULT_BANNER_W * DEFAULT_BANNER_H;
  localparam int unsigned ADDR_W           = 12;

  typedef enum logic {
    OP_CLEAR = 1'b0,
    OP_LOAD  = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/banner_writer_if.sv
// Command, image ROM, overlay RAM write and visibility signals of the banner writer.
interface banner_writer_if
  import banner_pkg::*;
#(
  parameter int unsigned SEL_W = 2
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  op_t                     cmd_op;
  logic [SEL_W-1:0]        cmd_sel;
  logic                    frame_start;
  logic [SEL_W+ADDR_W-1:0] src_addr;
  logic [1:0]              src_data;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [1:0]              wr_data;
  logic                    done;
  logic                    banner_visible;

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, frame_start, src_data,
    output cmd_ready, src_addr, wr_en, wr_addr, wr_data, done, banner_visible
  );

  modport master (
    output cmd_valid, cmd_op, cmd_sel, frame_start, src_data,
    input  cmd_ready, src_addr, wr_en, wr_addr, wr_data, done, banner_visible
  );

endinterface

// File: rtl/banner_pixel_counter.sv
// 12-bit pixel index counter: load-to-zero, enable, saturates at the last banner pixel.
module banner_pixel_counter
  import banner_pkg::*;
#(
  parameter int unsigned PIXELS = BANNER_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              last_c
);

  assign last_c = (count == ADDR_W'(PIXELS - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !last_c) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/banner_writer.sv
// Copies a stored banner image into the overlay RAM (or clears it) and gates
// banner visibility to frame boundaries.
module banner_writer
  import banner_pkg::*;
#(
  parameter int unsigned BANNER_W = DEFAULT_BANNER_W,
  parameter int unsigned BANNER_H = DEFAULT_BANNER_H,
  parameter int unsigned SEL_W    = 2
) (
  input  logic            vga_clk,
  input  logic            reset,
  banner_writer_if.slave  bus
);

  localparam int unsigned PIXELS = BANNER_W * BANNER_H;

  state_t            state_q, state_d;
  op_t               op_q;
  logic [SEL_W-1:0]  sel_q;
  logic              tail_q, tail_d;
  logic [ADDR_W-1:0] k;
  logic              k_last_c;
  logic              k_clr, k_en;
  logic              accept_c;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              show_pending_q;
  logic              visible_q;

  banner_pixel_counter #(
    .PIXELS (PIXELS)
  ) u_counter (
    .clk    (vga_clk),
    .reset  (reset),
    .clear  (k_clr),
    .en     (k_en),
    .count  (k),
    .last_c (k_last_c)
  );

  assign accept_c = bus.cmd_valid && (state_q == ST_IDLE);

  // Next state plus the next values of the registered write port; LOAD writes
  // trail the ROM address by one cycle, so the write uses the current k.
  always_comb begin
    state_d   = state_q;
    tail_d    = tail_q;
    k_clr     = 1'b0;
    k_en      = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          k_clr  = 1'b1;
          tail_d = 1'b0;
          if (bus.cmd_op == OP_CLEAR) begin
            state_d   = ST_CLEAR;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = 2'b00;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_CLEAR: begin
        if (k_last_c) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          k_en      = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = k + ADDR_W'(1);
          wr_data_d = 2'b00;
        end
      end
      ST_LOAD: begin
        if (tail_q) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          tail_d  = 1'b0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = k;
          wr_data_d = bus.src_data;
          if (k_last_c) begin
            tail_d = 1'b1;
          end else begin
            k_en = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLEAR;
      sel_q     <= '0;
      tail_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tail_q    <= tail_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      if (accept_c) begin
        op_q  <= bus.cmd_op;
        sel_q <= bus.cmd_sel;
      end
    end
  end

  // show_pending arms at the end of a finished LOAD, so a frame_start during
  // the FINISH cycle cannot expose the banner early.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      show_pending_q <= 1'b0;
      visible_q      <= 1'b0;
    end else if (accept_c) begin
      show_pending_q <= 1'b0;
      visible_q      <= 1'b0;
    end else if (state_q == ST_FINISH && op_q == OP_LOAD) begin
      show_pending_q <= 1'b1;
    end else if (bus.frame_start && show_pending_q) begin
      show_pending_q <= 1'b0;
      visible_q      <= 1'b1;
    end
  end

  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.src_addr       = {sel_q, k};
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.done           = done_q;
  assign bus.banner_visible = visible_q;

endmodule

// File: tb/tb_banner_writer.sv
// Directed bench for banner_writer: LOAD/CLEAR sequencing, write stream, visibility gating, reset.
module tb_banner_writer;
  import banner_pkg::*;

  localparam int P = 3600;

  logic clk = 1'b0;
  logic reset;

  banner_writer_if #(.SEL_W(2)) bus ();

  banner_writer #(
    .BANNER_W (80),
    .BANNER_H (45),
    .SEL_W    (2)
  ) dut (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Image ROM model: returns the low two address bits.
  assign bus.src_data = bus.src_addr[1:0];

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int n_wr, n_bad, done_cyc, first_wr_cyc, ready_seen;
  logic [13:0] first_src, last_src;
  logic vis_acc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one command and follow it cycle by cycle until done (or the abort write count).
  task automatic run_cmd(input op_t op, input logic [1:0] sel, input int abort_at, input bit hold);
    logic [1:0] ed;
    n_wr = 0; n_bad = 0; done_cyc = 0; first_wr_cyc = 0; ready_seen = 0;
    last_src = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    step();
    if (hold) bus.cmd_op = OP_CLEAR;
    else bus.cmd_valid = 1'b0;
    first_src = bus.src_addr;
    vis_acc   = bus.banner_visible;
    for (int c = 1; c <= P + 10; c++) begin
      if (bus.wr_en === 1'b1) begin
        ed = (op == OP_LOAD) ? 2'(n_wr) : 2'b00;
        if (bus.wr_addr !== 12'(n_wr) || bus.wr_data !== ed) n_bad++;
        if (n_wr == 0) first_wr_cyc = c;
        n_wr++;
      end
      if (c == P) last_src = bus.src_addr;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (bus.cmd_ready === 1'b1) ready_seen++;
      if (abort_at != 0 && n_wr == abort_at) break;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = OP_CLEAR;
    bus.cmd_sel     = 2'd0;
    bus.frame_start = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();

    // Reset / idle state
    check("rst_ready",   32'(bus.cmd_ready),      32'd1);
    check("rst_wr_en",   32'(bus.wr_en),          32'd0);
    check("rst_visible", 32'(bus.banner_visible), 32'd0);
    check("rst_done",    32'(bus.done),           32'd0);
    check("rst_src",     32'(bus.src_addr),       32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr),        32'd0);
    bus.frame_start = 1'b1; step(); step();
    bus.frame_start = 1'b0; step();
    check("idle_frame_vis", 32'(bus.banner_visible), 32'd0);

    // LOAD image 2
    run_cmd(OP_LOAD, 2'd2, 0, 1'b0);
    check("load_first_src", 32'(first_src),    32'h2000);
    check("load_last_src",  32'(last_src),     32'h2E0F);
    check("load_writes",    32'(n_wr),         32'd3600);
    check("load_bad",       32'(n_bad),        32'd0);
    check("load_first_wr",  32'(first_wr_cyc), 32'd2);
    check("load_done_cyc",  32'(done_cyc),     32'd3602);
    check("load_busy",      32'(ready_seen),   32'd0);
    check("load_vis_done",  32'(bus.banner_visible), 32'd0);

    // frame_start in the done cycle must not promote the banner
    bus.frame_start = 1'b1; step();
    bus.frame_start = 1'b0;
    check("done_pulse_once", 32'(bus.done), 32'd0);
    check("vis_fs_in_done",  32'(bus.banner_visible), 32'd0);
    step();
    bus.frame_start = 1'b1; step();
    bus.frame_start = 1'b0;
    check("vis_next_fs", 32'(bus.banner_visible), 32'd1);
    step();

    // CLEAR after LOAD
    run_cmd(OP_CLEAR, 2'd3, 0, 1'b0);
    check("clr_vis_accept", 32'(vis_acc),      32'd0);
    check("clr_writes",     32'(n_wr),         32'd3600);
    check("clr_bad",        32'(n_bad),        32'd0);
    check("clr_first_wr",   32'(first_wr_cyc), 32'd1);
    check("clr_done_cyc",   32'(done_cyc),     32'd3601);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      bus.frame_start = 1'b1; step();
      bus.frame_start = 1'b0;
      check("clr_vis_frame", 32'(bus.banner_visible), 32'd0);
    end
    step();

    // cmd_valid held (as CLEAR) throughout a LOAD
    run_cmd(OP_LOAD, 2'd1, 0, 1'b1);
    check("hold_first_src", 32'(first_src),  32'h1000);
    check("hold_writes",    32'(n_wr),       32'd3600);
    check("hold_bad",       32'(n_bad),      32'd0);
    check("hold_done_cyc",  32'(done_cyc),   32'd3602);
    check("hold_busy",      32'(ready_seen), 32'd0);
    step();
    check("hold_ready_after", 32'(bus.cmd_ready), 32'd1);
    check("hold_no_wr_idle",  32'(bus.wr_en),     32'd0);
    step();
    bus.cmd_valid = 1'b0;
    check("hold_clr_wr_en",   32'(bus.wr_en),   32'd1);
    check("hold_clr_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("hold_clr_wr_data", 32'(bus.wr_data), 32'd0);
    cnt = 0;
    for (int c = 0; c <= P + 10; c++) begin
      if (bus.wr_en === 1'b1) cnt++;
      if (bus.done === 1'b1) break;
      step();
    end
    check("hold_clr_writes", 32'(cnt), 32'd3600);
    step(); step();

    // Reset at write #1000 of a LOAD, then a normal LOAD
    run_cmd(OP_LOAD, 2'd3, 1000, 1'b0);
    check("abort_writes", 32'(n_wr), 32'd1000);
    reset = 1'b1; step();
    reset = 1'b0;
    check("abort_wr_en",   32'(bus.wr_en),          32'd0);
    check("abort_done",    32'(bus.done),           32'd0);
    check("abort_ready",   32'(bus.cmd_ready),      32'd1);
    check("abort_visible", 32'(bus.banner_visible), 32'd0);
    run_cmd(OP_LOAD, 2'd0, 0, 1'b0);
    check("post_first_src", 32'(first_src), 32'h0000);
    check("post_last_src",  32'(last_src),  32'h0E0F);
    check("post_writes",    32'(n_wr),      32'd3600);
    check("post_bad",       32'(n_bad),     32'd0);
    check("post_done_cyc",  32'(done_cyc),  32'd3602);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
